// File: rtl/game_pkg.sv
// Shared definitions for the game frame sequencer: state encoding,
// default frame timing and lives width.
package game_pkg;

  localparam int LIVES_W                 = 3;
  localparam int TICKS_PER_FRAME_DEFAULT = 833333;
  localparam int START_LIVES_DEFAULT     = 3;

  // Encoding is visible on state_o (debug LEDs), so values are fixed.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    SHIP = 3'd2,
    GRID = 3'd3,
    DRAW = 3'd4,
    OVER = 3'd5
  } state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Reloading down-counter. While en is high it counts PERIOD cycles and
// raises tick during the last one; clr (or the tick itself) reloads it.
module frame_tick_gen #(
  parameter int PERIOD = 4,
  parameter int W      = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [W-1:0] LOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == '0);

  // Count down while enabled; reload on clear or at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= LOAD;
    else if (clr || tick) cnt <= LOAD;
    else if (en)          cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/game_frame_ctrl.sv
// Frame sequencer: waits one frame period, strobes ship then grid update,
// kicks the draw engine and waits for draw_done (or a timeout), while
// tracking lives from hit pulses. Optional macro FRAME_CTRL_PAUSE_EN adds
// a pause input that freezes the WAIT period and ignores hits while paused.
module game_frame_ctrl
  import game_pkg::*;
#(
  parameter int TICKS_PER_FRAME = TICKS_PER_FRAME_DEFAULT,
  parameter int CNT_W           = 20,
  parameter int START_LIVES     = START_LIVES_DEFAULT,
  parameter int DRAW_TIMEOUT    = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         hit,
  input  logic         draw_done,
`ifdef FRAME_CTRL_PAUSE_EN
  input  logic         pause,
`endif
  output logic         ship_update_en,
  output logic         grid_update_en,
  output logic         draw_start,
  output logic [2:0]   lives,
  output logic         game_over,
  output logic [15:0]  frame_cnt,
  output logic [2:0]   state_o
);

  localparam int TO_W = $clog2(DRAW_TIMEOUT + 1);

  state_t               state, state_nx;
  logic [LIVES_W-1:0]   lives_nx;
  logic [15:0]          frame_nx;
  logic                 ship_nx, grid_nx, draw_nx;
  logic                 paused, wait_run, frame_tick, draw_tick, hit_ok;

`ifdef FRAME_CTRL_PAUSE_EN
  assign paused = (state == WAIT) && pause;
`else
  assign paused = 1'b0;
`endif

  assign wait_run = (state == WAIT) && !paused;
  assign hit_ok   = hit && !paused &&
                    (state == WAIT || state == SHIP || state == GRID || state == DRAW);

  frame_tick_gen #(.PERIOD(TICKS_PER_FRAME), .W(CNT_W)) u_frame_tick (
    .clk   (clk),
    .reset (reset),
    .en    (wait_run),
    .clr   (state != WAIT),
    .tick  (frame_tick)
  );

  frame_tick_gen #(.PERIOD(DRAW_TIMEOUT), .W(TO_W)) u_draw_timeout (
    .clk   (clk),
    .reset (reset),
    .en    (state == DRAW),
    .clr   (state != DRAW),
    .tick  (draw_tick)
  );

  // Next state, lives and frame count; losing the last life overrides all.
  always_comb begin
    state_nx = state;
    lives_nx = lives;
    frame_nx = frame_cnt;
    case (state)
      IDLE, OVER: if (start) begin
        state_nx = WAIT;
        lives_nx = LIVES_W'(START_LIVES);
        frame_nx = '0;
      end
      WAIT: if (frame_tick) state_nx = SHIP;
      SHIP: state_nx = GRID;
      GRID: state_nx = DRAW;
      DRAW: if (draw_done || draw_tick) begin
        state_nx = WAIT;
        frame_nx = frame_cnt + 16'd1;
      end
      default: state_nx = IDLE;
    endcase
    if (hit_ok) begin
      if (lives == LIVES_W'(1)) begin
        lives_nx = '0;
        state_nx = OVER;
        frame_nx = frame_cnt;
      end else if (lives != '0) begin
        lives_nx = lives - 1'b1;
      end
    end
    ship_nx = (state_nx == SHIP);
    grid_nx = (state_nx == GRID);
    draw_nx = (state_nx == DRAW) && (state != DRAW);
  end

  // State, counters and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lives          <= '0;
      frame_cnt      <= '0;
      ship_update_en <= 1'b0;
      grid_update_en <= 1'b0;
      draw_start     <= 1'b0;
    end else begin
      state          <= state_nx;
      lives          <= lives_nx;
      frame_cnt      <= frame_nx;
      ship_update_en <= ship_nx;
      grid_update_en <= grid_nx;
      draw_start     <= draw_nx;
    end
  end

  assign game_over = (state == OVER);
  assign state_o   = state;

endmodule

// File: doc/game_frame_ctrl.md
Name: game_frame_ctrl

Overview:
- Frame sequencer for the game datapath: paces the ship/enemy movement and grid-shift logic at a fixed frame rate.
- Issues one-cycle `ship_update_en` / `grid_update_en` strobes in a fixed order each frame, then hands off to the VGA draw engine and waits for its done pulse.
- Tracks player lives from hit events and enters a game-over state when they are exhausted.
- Sits between the top level (keys, VGA draw engine) and the datapath.

Parameters:
- TICKS_PER_FRAME, 833333, clk cycles per frame (50 MHz / 60 Hz); must be ≥ 4.
- CNT_W, 20, frame counter width; must satisfy 2^CNT_W > TICKS_PER_FRAME.
- START_LIVES, 3, lives loaded at game start; range 1..7.
- DRAW_TIMEOUT, 65535, max cycles to wait for `draw_done` before forcing the next frame.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begins a game from IDLE or OVER
- hit  in  1  one-cycle pulse: enemy shot reached the user ship
- draw_done  in  1  one-cycle pulse from the draw engine: frame drawn
- ship_update_en  out  1  one-cycle strobe to datapath shipUpdateEn
- grid_update_en  out  1  one-cycle strobe to datapath gridUpdateEn
- draw_start  out  1  one-cycle strobe to the draw engine
- lives  out  3  remaining lives
- game_over  out  1  high while in OVER
- frame_cnt  out  16  frames completed since start; wraps at 0xFFFF
- state_o  out  3  current FSM state, for debug LEDs

Behaviour:
- Reset (async assert, synchronous release) drives:
  - state = IDLE
  - all strobes = 0
  - lives = 0
  - game_over = 0
  - frame_cnt = 0
  - tick counter = 0
- States and transitions (encoding: IDLE=0, WAIT=1, SHIP=2, GRID=3, DRAW=4, OVER=5):
  - IDLE: on `start`=1 → WAIT next cycle; lives ← START_LIVES; tick counter ← 0.
  - WAIT: tick counter increments each cycle. When it equals TICKS_PER_FRAME-1 → SHIP and the counter clears.
  - SHIP: `ship_update_en`=1 for exactly this cycle → GRID.
  - GRID: `grid_update_en`=1 for exactly this cycle → DRAW.
  - DRAW:
    - On entry cycle, `draw_start`=1 for one cycle; a timeout counter starts.
    - `draw_done` pulse → WAIT, frame_cnt+1.
    - Timeout counter reaches DRAW_TIMEOUT → WAIT, frame_cnt+1 (forced).
  - OVER: `game_over`=1. On `start`=1 → WAIT with lives reloaded, frame_cnt ← 0.
- Strobes are registered outputs, asserted in the cycle the state register holds SHIP/GRID/DRAW-entry. Strobes are never asserted outside those states.
- Frame period from the first SHIP strobe to the next is exactly TICKS_PER_FRAME + 3 + (draw latency) cycles. The tick counter does not run in SHIP/GRID/DRAW.
- Hit handling:
  - A `hit` in WAIT, SHIP, GRID or DRAW decrements lives, saturating at 0.
  - If lives is 1 when `hit` arrives, lives → 0 and state → OVER next cycle, overriding any other transition that cycle. An in-flight draw is abandoned; no further strobes are issued.
  - `hit` in IDLE or OVER is ignored.
- Simultaneous events:
  - `hit` and `draw_done` in the same cycle: the lives decrement applies. OVER takes precedence over WAIT; otherwise the state goes → WAIT.
  - `draw_done` outside DRAW is ignored.
- `start` held high across OVER → WAIT restarts only once; the level is sampled only in IDLE/OVER.
- Reset mid-frame returns to IDLE immediately. Partially issued strobes drop within the same cycle.

Optional Feature:
- Macro: FRAME_CTRL_PAUSE_EN.
- With the macro defined:
  - Adds input port `pause` (1 bit, level).
  - While `pause`=1 in WAIT: the tick counter holds, no transition to SHIP occurs, and `hit` is ignored.
  - A frame already in SHIP/GRID/DRAW completes normally, then the block holds in WAIT.
  - state_o reports WAIT while paused.
- Without the macro: no `pause` port; WAIT always counts.

Decomposition:
- Package `game_pkg` holds:
  - state encoding constants IDLE..OVER (3-bit)
  - TICKS_PER_FRAME_DEFAULT
  - START_LIVES_DEFAULT
  - the LIVES_W=3 constant
- Natural sub-module: `frame_tick_gen`.
  - Parameterised down-counter with `en` and `clr` inputs.
  - Produces a one-cycle `tick` at terminal count.
  - Used for both the WAIT tick counter and the DRAW timeout.

Test Plan:
- TICKS_PER_FRAME=4, reset then `start` pulse, `draw_done` 2 cycles after each `draw_start` → strobes in order ship, grid, draw_start; period 4+3+2=9 cycles; frame_cnt=3 after 3 frames.
- START_LIVES=2, `hit` pulses in two separate WAIT cycles → lives 2→1→0; game_over=1 on the cycle after the second hit; no further strobes for 50 cycles.
- `hit` coincident with `draw_done` while lives=3 → lives=2, state WAIT, frame_cnt+1.
- DRAW_TIMEOUT=8, `draw_done` never pulsed → return to WAIT exactly 8 cycles after `draw_start`; frame_cnt incremented.
- Assert `reset` asynchronously mid-GRID → all outputs zero before the next clk edge; state_o=0; `start` again resumes normal sequencing.
- FRAME_CTRL_PAUSE_EN defined, `pause`=1 for 20 cycles in WAIT → no strobes and the tick counter frozen; resumes with the remaining count after `pause` drops.
